game_round_controller: RTL and testbench
========================================

GAME_ROUND_CONTROLLER -- requirements
Module: game_round_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 3, giving N = WIDTH+1 LED/button lanes.
REQ-002 SHALL have parameter TIMEOUT, default 1000, giving the max osc_clk cycles allowed per round in WAIT.
REQ-003 SHALL have parameter ROUNDS, default 8, giving the number of rounds per game (1..255).
REQ-004 SHALL have port osc_clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit: request a new game; sampled only in IDLE or DONE.
REQ-007 SHALL have port button, input, WIDTH+1 bits: active-high player buttons.
REQ-008 SHALL have port led, output, WIDTH+1 bits: active-high LED drive.
REQ-009 SHALL have port score, output, 8 bits: hits in the current game.
REQ-010 SHALL have port busy, output, 1 bit: high in any state except IDLE and DONE.
REQ-011 SHALL have port game_over, output, 1 bit: high only in DONE.

Function
REQ-012 SHALL implement states IDLE, RELEASE, ARM, WAIT, HIT, MISS and DONE, with all outputs registered.
REQ-013 IDLE or DONE with start=1 SHALL clear score and the round counter and go to RELEASE; start in other states SHALL be ignored.
REQ-014 RELEASE SHALL hold led=0 and go to ARM on the first cycle with button==0.
REQ-015 ARM SHALL last one cycle: target = lfsr mod N, led = one-hot(target) from the next cycle, LFSR steps once, round timer cleared, next state WAIT.
REQ-016 LFSR SHALL be 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shift left, stepped only in ARM.
REQ-017 WAIT with button == one-hot(target) SHALL go to HIT on the next edge.
REQ-018 WAIT with button nonzero and != one-hot(target) SHALL go to MISS; correct plus wrong pressed together SHALL count as MISS.
REQ-019 WAIT with timer == TIMEOUT-1 and no button pressed SHALL go to MISS; a correct press in that same cycle SHALL take priority (HIT).
REQ-020 HIT SHALL last one cycle: score+1, saturating at 255; led = all ones.
REQ-021 MISS SHALL last one cycle: score unchanged; led = 0.
REQ-022 HIT and MISS SHALL increment the round counter and go to DONE when it reaches ROUNDS, else to RELEASE.
REQ-023 DONE SHALL drive led = all ones and game_over=1, hold score, and stay until start.
REQ-024 Button-to-HIT/MISS latency SHALL be 1 cycle without BUTTON_SYNC_EN and 3 cycles with it.

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE, led=0, score=0, busy=0, game_over=0, LFSR=0xA5, round counter and timer = 0.
REQ-026 Reset asserted mid-game SHALL abandon the game; on release the block SHALL wait in IDLE for start.

Configuration
REQ-027 With macro BUTTON_SYNC_EN defined, button SHALL pass through a two-flop synchronizer (reset to 0) before all FSM use.
REQ-028 Without BUTTON_SYNC_EN, button SHALL be used directly and no synchronizer flops SHALL exist.

Verification
REQ-029 Reset release, start pulse, buttons 0 -> RELEASE, then ARM, then WAIT with led=4'b0010 (0xA5 mod 4 = 1), busy=1.
REQ-030 In WAIT with target 1, button=4'b0010 -> HIT next cycle, score 0->1, led=4'b1111 for one cycle.
REQ-031 In WAIT with target 1, button=4'b1010 -> MISS, score unchanged, led=4'b0000.
REQ-032 No press for TIMEOUT cycles -> MISS exactly TIMEOUT cycles after WAIT entry; correct press on the last cycle -> HIT.
REQ-033 Play ROUNDS=8 all correct -> DONE, game_over=1, score=8, led=4'b1111; start while busy ignored; start in DONE clears score to 0.
REQ-034 reset_n pulsed low for 10 ns during WAIT -> immediate IDLE, led=0, score=0; next game's first target is again lane 1.

Source files
------------

// File: rtl/game_round_controller.sv
// game_round_controller: reaction game sequencer with LFSR-chosen targets.
// Define BUTTON_SYNC_EN to pass buttons through a two-flop synchronizer.
module game_round_controller #(
    parameter int WIDTH   = 3,
    parameter int TIMEOUT = 1000,
    parameter int ROUNDS  = 8
) (
    input  logic           osc_clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [WIDTH:0] button,
    output logic [WIDTH:0] led,
    output logic [7:0]     score,
    output logic           busy,
    output logic           game_over
);
    localparam int N  = WIDTH + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WIDTH:0] ALL_ON = '1;
    localparam logic [WIDTH:0] LANE0  = N'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RELEASE,
        S_ARM,
        S_WAIT,
        S_HIT,
        S_MISS,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [WIDTH:0] btn;
    logic [WIDTH:0] target_oh;
    logic [WIDTH:0] led_d;
    logic [7:0]     lfsr_q, lfsr_d;
    logic [7:0]     target_q, target_d;
    logic [7:0]     round_q, round_d, round_inc;
    logic [7:0]     score_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           busy_d, game_over_d;
    logic           hit, wrong, expired;

`ifdef BUTTON_SYNC_EN
    logic [WIDTH:0] sync_q1, sync_q2;

    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= button;
            sync_q2 <= sync_q1;
        end
    end

    assign btn = sync_q2;
`else
    assign btn = button;
`endif

    // A wrong lane pressed alongside the target is not an exact match.
    assign target_oh = LANE0 << target_q;
    assign hit       = (btn == target_oh);
    assign wrong     = (btn != '0) && !hit;
    assign expired   = (timer_q == TW'(TIMEOUT - 1));
    assign round_inc = round_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        target_d    = target_q;
        round_d     = round_q;
        timer_d     = timer_q;
        score_d     = score;
        led_d       = '0;
        busy_d      = 1'b1;
        game_over_d = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    score_d = '0;
                    round_d = '0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (btn == '0) state_d = S_ARM;
            end
            S_ARM: begin
                target_d = lfsr_q % 8'(N);
                lfsr_d   = {lfsr_q[6:0],
                            lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                timer_d  = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (hit) begin
                    state_d = S_HIT;
                    score_d = (score == 8'hFF) ? score : score + 8'd1;
                end else if (wrong || expired) begin
                    state_d = S_MISS;
                end
            end
            S_HIT, S_MISS: begin
                round_d = round_inc;
                state_d = (round_inc == 8'(ROUNDS)) ? S_DONE : S_RELEASE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register with it.
        unique case (state_d)
            S_WAIT: led_d = LANE0 << target_d;
            S_HIT:  led_d = ALL_ON;
            S_DONE: begin
                led_d       = ALL_ON;
                busy_d      = 1'b0;
                game_over_d = 1'b1;
            end
            S_IDLE: busy_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge osc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            lfsr_q    <= 8'hA5;
            target_q  <= '0;
            round_q   <= '0;
            timer_q   <= '0;
            score     <= '0;
            led       <= '0;
            busy      <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            target_q  <= target_d;
            round_q   <= round_d;
            timer_q   <= timer_d;
            score     <= score_d;
            led       <= led_d;
            busy      <= busy_d;
            game_over <= game_over_d;
        end
    end

endmodule

// File: tb/tb_game_round_controller.sv
// tb_game_round_controller: directed games with a cycle-tagged scoreboard.
// Targets come from a hand-stepped LFSR table starting at seed 0xA5.
`timescale 1ns/1ps
module tb_game_round_controller;
    localparam int TIMEOUT = 20;

    logic       osc_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start   = 1'b0;
    logic [3:0] button  = 4'b0000;
    logic [3:0] led;
    logic [7:0] score;
    logic       busy;
    logic       game_over;

    game_round_controller #(
        .WIDTH(3),
        .TIMEOUT(TIMEOUT),
        .ROUNDS(8)
    ) dut (
        .osc_clk(osc_clk),
        .reset_n(reset_n),
        .start(start),
        .button(button),
        .led(led),
        .score(score),
        .busy(busy),
        .game_over(game_over)
    );

    always #5 osc_clk = ~osc_clk;

    int cyc = 0;
    always @(posedge osc_clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        string      name;
        logic [3:0] led;
        logic [7:0] score;
        logic       busy;
        logic       go;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Lanes for successive ARM visits: lfsr mod 4 for A5,4A,95,2A,54,A9,...
    int tgt [18] = '{1, 2, 1, 2, 0, 1, 3, 3, 2, 1, 3, 3, 2, 1, 3, 2, 0, 1};
    int idx = 0;
    int sc  = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge osc_clk);
            while (q.size() > 0 && q[0].at <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.at < cyc) begin
                    failures++;
                    $display("FAIL %s: cycle %0d skipped, now %0d", e.name, e.at, cyc);
                end else if (led !== e.led || score !== e.score ||
                             busy !== e.busy || game_over !== e.go) begin
                    failures++;
                    $display("FAIL %s @%0d: got led=%b score=%0d busy=%b game_over=%b, want led=%b score=%0d busy=%b game_over=%b",
                             e.name, cyc, led, score, busy, game_over,
                             e.led, e.score, e.busy, e.go);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge osc_clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge osc_clk);
    endtask

    task automatic expect_at(input int at, input string name, input logic [3:0] l,
                             input int s, input logic b, input logic g);
        exp_t e;
        e.at    = at;
        e.name  = name;
        e.led   = l;
        e.score = 8'(s);
        e.busy  = b;
        e.go    = g;
        q.push_back(e);
    endtask

    task automatic start_game(input string name);
        expect_at(cyc + 1, name, 4'b0000, 0, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        sc = 0;
    endtask

    // Entered on the negedge where RELEASE first shows; returns likewise.
    task automatic run_round(input string name, input bit correct,
                             input logic [3:0] wrong_press, input int delay,
                             input bit exp_hit, input bit poke, input bit last);
        int         r;
        int         o;
        logic [3:0] oh;
        logic [3:0] press;
        string      tag;
        r     = cyc;
        o     = r + 3 + delay;
        oh    = 4'b0001 << tgt[idx];
        press = correct ? oh : wrong_press;
        idx++;
        expect_at(r + 2, {name, " wait"}, oh, sc, 1'b1, 1'b0);
        if (exp_hit) begin
            sc++;
            tag = " hit";
        end else begin
            tag = " miss";
        end
        expect_at(o, {name, tag}, exp_hit ? 4'b1111 : 4'b0000, sc, 1'b1, 1'b0);
        if (last)
            expect_at(o + 1, {name, " done"}, 4'b1111, sc, 1'b0, 1'b1);
        else
            expect_at(o + 1, {name, " release"}, 4'b0000, sc, 1'b1, 1'b0);
        if (poke) begin
            wait_until(r + 2);
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_until(o - 1);
        button = press;
        tick();
        button = 4'b0000;
        tick();
    endtask

    initial begin
        int r;
        tick();
        tick();
        expect_at(cyc + 1, "reset", 4'b0000, 0, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        expect_at(cyc + 2, "idle hold", 4'b0000, 0, 1'b0, 1'b0);
        tick();
        tick();

        start_game("A start");
        run_round("A1", 1'b1, 4'b0000, 0, 1'b1, 1'b0, 1'b0);
        run_round("A2", 1'b0, 4'b0001, 3, 1'b0, 1'b0, 1'b0);
        run_round("A3 timeout", 1'b0, 4'b0000, TIMEOUT - 1, 1'b0, 1'b0, 1'b0);
        run_round("A4 last-cycle", 1'b1, 4'b0000, TIMEOUT - 1, 1'b1, 1'b0, 1'b0);
        run_round("A5 busy-start", 1'b1, 4'b0000, 4, 1'b1, 1'b1, 1'b0);
        run_round("A6", 1'b1, 4'b0000, 1, 1'b1, 1'b0, 1'b0);
        run_round("A7", 1'b1, 4'b0000, 2, 1'b1, 1'b0, 1'b0);
        run_round("A8", 1'b1, 4'b0000, 0, 1'b1, 1'b0, 1'b1);

        button = 4'b1111;
        expect_at(cyc + 3, "A done hold", 4'b1111, 6, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        button = 4'b0000;

        start_game("B start");
        for (int i = 0; i < 8; i++)
            run_round($sformatf("B%0d", i + 1), 1'b1, 4'b0000, 1, 1'b1,
                      1'b0, i == 7);

        start_game("C start");
        run_round("C1", 1'b1, 4'b0000, 2, 1'b1, 1'b0, 1'b0);
        r = cyc;
        expect_at(r + 2, "C2 wait", 4'b0010, 1, 1'b1, 1'b0);
        wait_until(r + 3);
        @(posedge osc_clk);
        #1 reset_n = 1'b0;
        expect_at(cyc, "async reset", 4'b0000, 0, 1'b0, 1'b0);
        #10 reset_n = 1'b1;
        tick();
        idx = 0;
        sc  = 0;
        expect_at(cyc + 1, "idle after reset", 4'b0000, 0, 1'b0, 1'b0);
        tick();

        start_game("D start");
        run_round("D1 combo", 1'b0, 4'b1010, 1, 1'b0, 1'b0, 1'b0);

        tick();
        tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending: %0d expectations unobserved, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
